fft_peak_detect: RTL and testbench
==================================

Name: fft_peak_detect

Overview:
- Downstream of the 128-point FFT core; consumes its Avalon-ST output stream (sop/eop framed complex bins, 32-bit signed real/imag).
- Computes a per-bin magnitude estimate (alpha-max-beta-min, alpha=1, beta=1/2) and tracks the strongest bin per frame.
- At end of frame, emits one result record through a valid/ready handshake: peak bin index, peak magnitude, threshold-detect flag and status.
- The radar display/Arduino link logic reads these records as target range/Doppler hits.

Parameters:
- DATA_W, 32, width of signed real/imag input samples.
- NPTS, 128, expected number of bins per frame.
- BIN_W, 7, width of bin index (clog2(NPTS)).
- SKIP_DC, 1, when 1, bin 0 is excluded from peak search (clutter rejection).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_error  in  2  upstream error code for this beat.
- in_sop  in  1  first bin of frame.
- in_eop  in  1  last bin of frame.
- in_real  in  DATA_W  signed real part.
- in_imag  in  DATA_W  signed imaginary part.
- threshold  in  DATA_W  unsigned detection threshold, quasi-static.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts result.
- res_bin  out  BIN_W  index of peak bin.
- res_mag  out  DATA_W  unsigned peak magnitude estimate.
- res_detect  out  1  res_mag >= threshold.
- res_status  out  2  bit0 framing error, bit1 upstream error seen.

Behaviour:
- Reset (async, reset_n=0): in_ready=0, res_valid=0, res_bin=0, res_mag=0, res_detect=0, res_status=0; FSM to IDLE, bin counter 0, pipeline empty. in_ready rises on the first clk edge after reset release. Reset mid-frame discards the frame; no result is produced.
- Beat accepted when in_valid & in_ready. in_ready = ~res_valid (registered): low from the cycle res_valid rises until the cycle after res_valid & res_ready.
- Magnitude: a=|in_real|, b=|in_imag| (unsigned DATA_W; |-2^31| = 2^31 exact). mag = max(a,b) + (min(a,b)>>1), DATA_W unsigned, no overflow possible.
- Pipeline: stage1 registers abs values + bin index + flags; stage2 registers mag; stage3 compare/update. Result res_valid asserts 3 cycles after the accepted eop beat.
- FSM states:
  - IDLE: accepted beats without sop are dropped. sop beat -> ACCUM, bin counter=0, peak cleared.
  - ACCUM: each accepted beat is assigned bin = counter, counter++. sop in ACCUM abandons the current frame silently and restarts at bin 0 with that beat. eop -> FLUSH.
  - FLUSH: wait for pipeline drain, load result registers, res_valid=1 -> HOLD.
  - HOLD: res_valid held with all res_* stable until res_ready; then -> IDLE.
- Peak update: strict greater-than, so ties keep the lowest bin. Peak register initialised to mag=0, bin=0. With SKIP_DC=1, bin 0 never updates the peak. An all-zero frame (or only DC nonzero) reports bin 0, mag 0.
- Framing error (status bit0): eop arrives with bin != NPTS-1, or counter reaches NPTS-1 without eop. In the second case, the frame is closed at bin NPTS-1 as if eop were present; further beats are dropped until the next sop.
- status bit1: OR of (in_error != 0) over all accepted beats in the frame.
- res_detect = (res_mag >= threshold), with threshold sampled at FLUSH.
- sop and eop on the same beat: single-bin frame, status bit0=1 (for NPTS>1).

Test Plan:
- Reset, then a 128-bin frame: zeros except bin 37 = (re=1000, im=-400) -> res_valid 3 cycles after eop, res_bin=37, res_mag=1200, res_status=0.
- Bins 5 and 90 both (re=-2^31, im=0), threshold=2^31 -> res_bin=5, res_mag=2^31, res_detect=1.
- SKIP_DC=1 with bin 0 = (5000,5000) and bin 64 = (10,0) -> res_bin=64, res_mag=10.
- eop at bin 99, in_error=2'b01 on bin 3 -> res_status=2'b11. Second sop mid-frame -> result covers only the restarted frame.
- Hold res_ready=0 for 20 cycles -> in_ready=0 and res_* stable throughout. Pulse res_ready -> in_ready=1 next cycle and the next frame processes normally.
- Assert reset_n low at bin 60 -> outputs at reset values immediately. After release, a clean frame yields the correct result and no stale record.

Source files
------------

// File: rtl/fft_peak_detect.sv
// Peak-bin detector for the FFT output stream: alpha-max-beta-min magnitude per bin,
// strongest-bin tracking per frame, one result record per frame over valid/ready.
module fft_peak_detect #(
    parameter int DATA_W  = 32,
    parameter int NPTS    = 128,
    parameter int BIN_W   = 7,
    parameter int SKIP_DC = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_error,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic [DATA_W-1:0] threshold,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [BIN_W-1:0]  res_bin,
    output logic [DATA_W-1:0] res_mag,
    output logic              res_detect,
    output logic [1:0]        res_status
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NPTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH,
        ST_HOLD
    } state_t;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? -x : x;
    endfunction

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;

    logic                s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]   s1_a_q, s1_a_d;
    logic [DATA_W-1:0]   s1_b_q, s1_b_d;
    logic [BIN_W-1:0]    s1_bin_q, s1_bin_d;
    logic                s1_first_q, s1_first_d;
    logic                s1_last_q, s1_last_d;
    logic                s1_err_q, s1_err_d;
    logic                s1_ferr_q, s1_ferr_d;

    logic                s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]   s2_mag_q, s2_mag_d;
    logic [BIN_W-1:0]    s2_bin_q, s2_bin_d;
    logic                s2_first_q, s2_first_d;
    logic                s2_last_q, s2_last_d;
    logic                s2_err_q, s2_err_d;
    logic                s2_ferr_q, s2_ferr_d;

    logic [DATA_W-1:0]   pk_mag_q, pk_mag_d;
    logic [BIN_W-1:0]    pk_bin_q, pk_bin_d;
    logic                err_acc_q, err_acc_d;
    logic                ferr_acc_q, ferr_acc_d;
    logic                s3_done_q, s3_done_d;

    logic                res_valid_q, res_valid_d;
    logic [BIN_W-1:0]    res_bin_q, res_bin_d;
    logic [DATA_W-1:0]   res_mag_q, res_mag_d;
    logic                res_detect_q, res_detect_d;
    logic [1:0]          res_status_q, res_status_d;

    logic                accept;
    logic                take;
    logic [BIN_W-1:0]    beat_bin;
    logic                at_end;
    logic [DATA_W-1:0]   mx, mn;
    logic [DATA_W-1:0]   base_mag;
    logic [BIN_W-1:0]    base_bin;
    logic                eligible;

    // Frame control: bin numbering, framing checks and result hand-off.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        res_valid_d  = res_valid_q;
        res_bin_d    = res_bin_q;
        res_mag_d    = res_mag_q;
        res_detect_d = res_detect_q;
        res_status_d = res_status_q;

        accept   = in_valid & in_ready_q;
        beat_bin = in_sop ? '0 : cnt_q;
        take     = accept && ((state_q == ST_IDLE && in_sop) || state_q == ST_ACCUM);
        at_end   = (beat_bin == LAST_BIN);

        s1_valid_d = take;
        s1_a_d     = abs_val(in_real);
        s1_b_d     = abs_val(in_imag);
        s1_bin_d   = beat_bin;
        s1_first_d = in_sop;
        s1_last_d  = in_eop | at_end;
        s1_err_d   = |in_error;
        // eop off the last bin, or the last bin without eop, are both framing errors
        s1_ferr_d  = in_eop ^ at_end;

        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (take) begin
                    cnt_d   = beat_bin + 1'b1;
                    state_d = (in_eop | at_end) ? ST_FLUSH : ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                if (s3_done_q) begin
                    res_valid_d  = 1'b1;
                    res_bin_d    = pk_bin_q;
                    res_mag_d    = pk_mag_q;
                    res_detect_d = (pk_mag_q >= threshold);
                    res_status_d = {err_acc_q, ferr_acc_q};
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = ~res_valid_d;
    end

    // Magnitude stage and peak compare stage.
    always_comb begin
        mx = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
        mn = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;

        s2_valid_d = s1_valid_q;
        s2_mag_d   = mx + (mn >> 1);
        s2_bin_d   = s1_bin_q;
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
        s2_err_d   = s1_err_q;
        s2_ferr_d  = s1_ferr_q;

        base_mag = s2_first_q ? '0 : pk_mag_q;
        base_bin = s2_first_q ? '0 : pk_bin_q;
        eligible = !((SKIP_DC != 0) && (s2_bin_q == '0));

        pk_mag_d   = pk_mag_q;
        pk_bin_d   = pk_bin_q;
        err_acc_d  = err_acc_q;
        ferr_acc_d = ferr_acc_q;
        s3_done_d  = s2_valid_q & s2_last_q;

        if (s2_valid_q) begin
            pk_mag_d   = base_mag;
            pk_bin_d   = base_bin;
            err_acc_d  = (s2_first_q ? 1'b0 : err_acc_q) | s2_err_q;
            ferr_acc_d = (s2_first_q ? 1'b0 : ferr_acc_q) | s2_ferr_q;
            // strict compare keeps the lowest bin on ties
            if (eligible && (s2_mag_q > base_mag)) begin
                pk_mag_d = s2_mag_q;
                pk_bin_d = s2_bin_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_bin_q     <= '0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_ferr_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_mag_q     <= '0;
            s2_bin_q     <= '0;
            s2_first_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_err_q     <= 1'b0;
            s2_ferr_q    <= 1'b0;
            pk_mag_q     <= '0;
            pk_bin_q     <= '0;
            err_acc_q    <= 1'b0;
            ferr_acc_q   <= 1'b0;
            s3_done_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_bin_q    <= '0;
            res_mag_q    <= '0;
            res_detect_q <= 1'b0;
            res_status_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_bin_q     <= s1_bin_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            s1_err_q     <= s1_err_d;
            s1_ferr_q    <= s1_ferr_d;
            s2_valid_q   <= s2_valid_d;
            s2_mag_q     <= s2_mag_d;
            s2_bin_q     <= s2_bin_d;
            s2_first_q   <= s2_first_d;
            s2_last_q    <= s2_last_d;
            s2_err_q     <= s2_err_d;
            s2_ferr_q    <= s2_ferr_d;
            pk_mag_q     <= pk_mag_d;
            pk_bin_q     <= pk_bin_d;
            err_acc_q    <= err_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            s3_done_q    <= s3_done_d;
            res_valid_q  <= res_valid_d;
            res_bin_q    <= res_bin_d;
            res_mag_q    <= res_mag_d;
            res_detect_q <= res_detect_d;
            res_status_q <= res_status_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign res_valid  = res_valid_q;
    assign res_bin    = res_bin_q;
    assign res_mag    = res_mag_q;
    assign res_detect = res_detect_q;
    assign res_status = res_status_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: hand-built frames with hand-computed peak records.
module tb_fft_peak_detect;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_error;
    logic        in_sop;
    logic        in_eop;
    logic [31:0] in_real;
    logic [31:0] in_imag;
    logic [31:0] threshold;
    logic        res_valid;
    logic        res_ready;
    logic [6:0]  res_bin;
    logic [31:0] res_mag;
    logic        res_detect;
    logic [1:0]  res_status;

    int n_tests;
    int n_fail;

    logic [31:0] re_v  [128];
    logic [31:0] im_v  [128];
    logic [1:0]  err_v [128];

    fft_peak_detect #(
        .DATA_W (32),
        .NPTS   (128),
        .BIN_W  (7),
        .SKIP_DC(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_error  (in_error),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .threshold (threshold),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_bin   (res_bin),
        .res_mag   (res_mag),
        .res_detect(res_detect),
        .res_status(res_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 128; i++) begin
            re_v[i]  = '0;
            im_v[i]  = '0;
            err_v[i] = '0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input logic sop, input logic eop, input logic [31:0] re,
                             input logic [31:0] im, input logic [1:0] err);
        int n;
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_real  = re;
        in_imag  = im;
        in_error = err;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_error = '0;
        in_real  = '0;
        in_imag  = '0;
    endtask

    task automatic play(input int nbins, input bit with_eop);
        for (int i = 0; i < nbins; i++)
            send_beat(i == 0, with_eop && (i == nbins - 1), re_v[i], im_v[i], err_v[i]);
    endtask

    task automatic expect_result(input string tag, input bit chk_lat, input logic [6:0] e_bin,
                                 input logic [31:0] e_mag, input logic e_det,
                                 input logic [1:0] e_st, input int hold_cycles);
        int lat;
        idle_inputs();
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 64'(res_valid), 64'd1);
        if (chk_lat) check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_bin"}, 64'(res_bin), 64'(e_bin));
        check({tag, "_mag"}, 64'(res_mag), 64'(e_mag));
        check({tag, "_detect"}, 64'(res_detect), 64'(e_det));
        check({tag, "_status"}, 64'(res_status), 64'(e_st));
        check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            check({tag, "_hold"}, 64'({res_valid, in_ready, res_bin, res_mag, res_detect, res_status}),
                  64'({1'b1, 1'b0, e_bin, e_mag, e_det, e_st}));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_released"}, 64'({res_valid, in_ready}), 64'b01);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        res_ready = 1'b0;
        threshold = '0;
        idle_inputs();
        clear_frame();

        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({in_ready, res_valid, res_bin, res_mag, res_detect, res_status}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready_rise", 64'(in_ready), 64'd1);

        // F1: single tone at bin 37, mag = 1000 + 400/2; threshold equal to mag
        clear_frame();
        re_v[37] = 32'd1000;
        im_v[37] = 32'hFFFF_FE70;
        threshold = 32'd1200;
        play(128, 1);
        expect_result("f1", 1, 7'd37, 32'd1200, 1'b1, 2'b00, 0);

        // F2: two equal full-scale negative bins, lower index wins
        clear_frame();
        re_v[5]  = 32'h8000_0000;
        re_v[90] = 32'h8000_0000;
        threshold = 32'h8000_0000;
        play(128, 1);
        expect_result("f2", 1, 7'd5, 32'h8000_0000, 1'b1, 2'b00, 0);

        // F3: strong DC bin ignored, threshold one above peak
        clear_frame();
        re_v[0]  = 32'd5000;
        im_v[0]  = 32'd5000;
        re_v[64] = 32'd10;
        threshold = 32'd11;
        play(128, 1);
        expect_result("f3", 1, 7'd64, 32'd10, 1'b0, 2'b00, 0);

        // F4: abandoned partial frame, restart, early eop at bin 99 with error on bin 3
        clear_frame();
        re_v[7]  = 32'd9999;
        err_v[2] = 2'b10;
        play(10, 0);
        clear_frame();
        err_v[3] = 2'b01;
        im_v[50] = 32'd300;
        threshold = 32'd301;
        play(100, 1);
        expect_result("f4", 1, 7'd50, 32'd300, 1'b0, 2'b11, 20);

        // F5: stray non-sop beats in idle are dropped
        for (int k = 0; k < 3; k++) send_beat(1'b0, 1'b0, 32'h7FFF_0000, 32'h7FFF_0000, 2'b11);
        idle_inputs();
        clear_frame();
        re_v[1] = 32'hFFFF_FFF9;
        im_v[1] = 32'd3;
        threshold = 32'd8;
        play(128, 1);
        expect_result("f5", 1, 7'd1, 32'd8, 1'b1, 2'b00, 0);

        // F6: no eop, closed at bin 127; trailing beat is dropped
        clear_frame();
        re_v[100] = 32'd50;
        im_v[100] = 32'd60;
        threshold = 32'd85;
        play(128, 0);
        send_beat(1'b0, 1'b0, 32'h7000_0000, 32'd0, 2'b01);
        expect_result("f6", 0, 7'd100, 32'd85, 1'b1, 2'b01, 0);

        // Reset in the middle of a frame
        clear_frame();
        re_v[20] = 32'd777;
        play(60, 0);
        reset_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({in_ready, res_valid, res_bin, res_mag, res_detect, res_status}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_stale", 64'({res_valid, in_ready}), 64'b01);

        clear_frame();
        im_v[127] = 32'hFFFF_FFEC;
        threshold = 32'd100;
        play(128, 1);
        expect_result("f7", 1, 7'd127, 32'd20, 1'b0, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1);
    end

endmodule
